// File: rtl/freq_meter_pkg.sv
// freq_meter_pkg: shared board constants and FSM state encoding for the frequency meter.
//   CLK_HZ      system clock rate on DE0
//   FREQ_CNT_W  default edge-counter / result width
//   state_t     ST_IDLE (not measuring), ST_MEASURE (gate window open)
package freq_meter_pkg;
    localparam int CLK_HZ     = 50_000_000;
    localparam int FREQ_CNT_W = 26;
    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_MEASURE = 1'b1
    } state_t;
endpackage

// File: rtl/freq_meter_sync_edge.sv
// sync_edge: multi-flop synchronizer for an asynchronous input plus a rising-edge pulse.
//   CLK   in  system clock
//   RST   in  asynchronous active-high reset
//   d     in  asynchronous level input
//   rise  out one-cycle pulse when the synchronized level goes 0->1
module sync_edge #(
    parameter int STAGES = 2
) (
    input  logic CLK,
    input  logic RST,
    input  logic d,
    output logic rise
);
    logic [STAGES-1:0] sync_q, sync_d;
    logic              prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
        prev_d = sync_q[STAGES-1];
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign rise = sync_q[STAGES-1] & ~prev_q;
endmodule

// File: rtl/freq_meter.sv
// freq_meter: counts rising edges of sig_in between consecutive gate_tick pulses.
//   CLK         in  system clock
//   RST         in  asynchronous active-high reset
//   en          in  measurement enable; low aborts the open window and idles
//   gate_tick   in  one-cycle gate pulse (CLK domain)
//   sig_in      in  measured signal, asynchronous to CLK
//   freq_out    out last completed window count (saturating), held between updates
//   freq_valid  out one-cycle strobe when freq_out/overflow update
//   overflow    out last completed window saturated
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int CNT_W       = FREQ_CNT_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             en,
    input  logic             gate_tick,
    input  logic             sig_in,
    output logic [CNT_W-1:0] freq_out,
    output logic             freq_valid,
    output logic             overflow
);
    state_t           state_q, state_d;
    logic [CNT_W-1:0] acc_q, acc_d;
    logic             sat_q, sat_d;
    logic [CNT_W-1:0] freq_q, freq_d;
    logic             valid_q, valid_d;
    logic             ovf_q, ovf_d;
    logic             rise;
    logic             full;

    sync_edge #(.STAGES(SYNC_STAGES)) u_sync (
        .CLK  (CLK),
        .RST  (RST),
        .d    (sig_in),
        .rise (rise)
    );

    assign full = &acc_q;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        sat_d   = sat_q;
        freq_d  = freq_q;
        valid_d = 1'b0;
        ovf_d   = ovf_q;
        if (state_q == ST_IDLE) begin
            acc_d = '0;
            sat_d = 1'b0;
            state_d = (gate_tick && en) ? ST_MEASURE : ST_IDLE;
        end else if (gate_tick) begin
            // A rise landing on the closing tick belongs to the closing window.
            freq_d  = (rise && !full) ? acc_q + CNT_W'(1) : acc_q;
            ovf_d   = sat_q | (rise & full);
            valid_d = 1'b1;
            acc_d   = '0;
            sat_d   = 1'b0;
            state_d = en ? ST_MEASURE : ST_IDLE;
        end else if (!en) begin
            acc_d   = '0;
            sat_d   = 1'b0;
            state_d = ST_IDLE;
        end else if (rise) begin
            acc_d = full ? acc_q : acc_q + CNT_W'(1);
            sat_d = sat_q | full;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            sat_q   <= 1'b0;
            freq_q  <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            sat_q   <= sat_d;
            freq_q  <= freq_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
        end
    end

    assign freq_out   = freq_q;
    assign freq_valid = valid_q;
    assign overflow   = ovf_q;
endmodule

// File: tb/tb_freq_meter.sv
// tb_freq_meter: directed self-checking bench for freq_meter (26-bit and 4-bit instances).
module tb_freq_meter;
    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        en = 1'b1;
    logic        gate_tick = 1'b0;
    logic        sig_in = 1'b0;
    logic        sig4 = 1'b0;
    logic [25:0] freq_out;
    logic        freq_valid;
    logic        overflow;
    logic [3:0]  freq4;
    logic        valid4;
    logic        ovf4;

    int checks = 0;
    int failures = 0;
    int t = 0;
    int nvalid = 0;
    int dbl = 0;
    logic valid_prev = 1'b0;

    always #5 CLK = ~CLK;

    freq_meter dut (
        .CLK        (CLK),
        .RST        (RST),
        .en         (en),
        .gate_tick  (gate_tick),
        .sig_in     (sig_in),
        .freq_out   (freq_out),
        .freq_valid (freq_valid),
        .overflow   (overflow)
    );

    freq_meter #(.CNT_W(4)) dut4 (
        .CLK        (CLK),
        .RST        (RST),
        .en         (en),
        .gate_tick  (gate_tick),
        .sig_in     (sig4),
        .freq_out   (freq4),
        .freq_valid (valid4),
        .overflow   (ovf4)
    );

    // Main signal: period-4 square wave, then hand-placed pulses and a held-high stretch.
    function automatic logic sig_at(int n);
        if (n <= 210 || n >= 715) return (n % 4) < 2;
        if ((n >= 250 && n <= 251) || (n >= 270 && n <= 271) || (n >= 308 && n <= 309)) return 1'b1;
        if ((n >= 330 && n <= 331) || (n >= 408 && n <= 409) || (n >= 420 && n <= 421)) return 1'b1;
        return n >= 460 && n < 620;
    endfunction

    // Narrow instance: 20 rises in the first window, 5 in the second.
    function automatic logic sig4_at(int n);
        return ((n >= 12 && n <= 89) || (n >= 112 && n <= 129)) && ((n % 4) < 2);
    endfunction

    task automatic step();
        t++;
        sig_in    = sig_at(t);
        sig4      = sig4_at(t);
        gate_tick = (t >= 10) && (t % 100 == 10);
        en        = !((t >= 750 && t < 770) || t >= 1210);
        @(posedge CLK);
        #1;
        if (freq_valid) nvalid++;
        if (freq_valid && valid_prev) dbl++;
        valid_prev = freq_valid;
    endtask

    task automatic run_to(int n);
        while (t < n) step();
    endtask

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        run_to(3);
        check("reset_freq", 32'(freq_out), 0);
        check("reset_valid", 32'(freq_valid), 0);
        check("reset_ovf", 32'(overflow), 0);
        check("reset_freq4", 32'(freq4), 0);
        RST = 1'b0;
        run_to(10);
        check("start_no_valid", 32'(freq_valid), 0);
        check("start_nvalid", 32'(nvalid), 0);
        run_to(110);
        check("w1_valid", 32'(freq_valid), 1);
        check("w1_freq", 32'(freq_out), 25);
        check("w1_ovf", 32'(overflow), 0);
        check("sat_freq4", 32'(freq4), 15);
        check("sat_ovf4", 32'(ovf4), 1);
        check("sat_valid4", 32'(valid4), 1);
        run_to(111);
        check("w1_strobe_drop", 32'(freq_valid), 0);
        check("w1_hold", 32'(freq_out), 25);
        run_to(210);
        check("w2_valid", 32'(freq_valid), 1);
        check("w2_freq", 32'(freq_out), 25);
        check("w2_ovf", 32'(overflow), 0);
        check("unsat_freq4", 32'(freq4), 5);
        check("unsat_ovf4", 32'(ovf4), 0);
        run_to(310);
        check("edge_at_gate_w1", 32'(freq_out), 3);
        check("edge_at_gate_valid", 32'(freq_valid), 1);
        run_to(410);
        check("edge_at_gate_w2", 32'(freq_out), 2);
        run_to(510);
        check("edge_w3", 32'(freq_out), 2);
        run_to(610);
        check("held_high_valid", 32'(freq_valid), 1);
        check("held_high_freq", 32'(freq_out), 0);
        run_to(710);
        check("held_low_valid", 32'(freq_valid), 1);
        check("held_low_freq", 32'(freq_out), 0);
        run_to(810);
        check("en_abort_no_valid", 32'(freq_valid), 0);
        check("en_abort_hold", 32'(freq_out), 0);
        check("en_abort_nvalid", 32'(nvalid), 7);
        run_to(910);
        check("en_restart_valid", 32'(freq_valid), 1);
        check("en_restart_freq", 32'(freq_out), 25);
        check("en_restart_nvalid", 32'(nvalid), 8);
        run_to(960);
        RST = 1'b1;
        #1;
        check("rst_mid_freq", 32'(freq_out), 0);
        check("rst_mid_ovf", 32'(overflow), 0);
        check("rst_mid_valid", 32'(freq_valid), 0);
        run_to(962);
        RST = 1'b0;
        run_to(1010);
        check("post_rst_no_valid", 32'(freq_valid), 0);
        run_to(1110);
        check("post_rst_valid", 32'(freq_valid), 1);
        check("post_rst_freq", 32'(freq_out), 25);
        run_to(1210);
        check("en_fall_gate_valid", 32'(freq_valid), 1);
        check("en_fall_gate_freq", 32'(freq_out), 25);
        run_to(1310);
        check("gate_en_low_ignored", 32'(freq_valid), 0);
        run_to(1400);
        check("total_valids", 32'(nvalid), 10);
        check("no_double_strobe", 32'(dbl), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
